// File: rtl/layer_scheduler_pkg.sv
// Shared NPU definitions: scheduler state encoding and index-width helper.
package npu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } sched_state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Host-side input/output vector streams of the layer scheduler.
interface layer_scheduler_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LAYERS = 4
);
  logic                               in_valid;
  logic                               in_ready;
  logic [N*DATA_WIDTH-1:0]            in_vec;
  logic [$clog2(NUM_LAYERS+1)-1:0]    num_layers_cfg;
  logic                               out_valid;
  logic                               out_ready;
  logic [N*DATA_WIDTH-1:0]            out_vec;

  modport master (
    output in_valid, in_vec, num_layers_cfg, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_vec, num_layers_cfg, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/layer_scheduler.sv
// Runs K fully-connected layers back to back through one shared Layer datapath,
// fetching each layer's weights/biases and feeding results back as activations.
module layer_scheduler
  import npu_pkg::*;
#(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_LAYERS    = 4,
  parameter int LAYER_LATENCY = 3,
  localparam int IW = idx_width(NUM_LAYERS),
  localparam int KW = $clog2(NUM_LAYERS + 1),
  localparam int CW = idx_width(LAYER_LATENCY),
  localparam int VW = N * DATA_WIDTH,
  localparam int WW = N * N * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  layer_scheduler_if.slave host,
  output logic          wmem_rd_en,
  output logic [IW-1:0] wmem_addr,
  input  logic [WW-1:0] wmem_weights,
  input  logic [VW-1:0] wmem_biases,
  output logic [VW-1:0] layer_in_vec,
  output logic [WW-1:0] layer_weights,
  output logic [VW-1:0] layer_biases,
  input  logic [VW-1:0] layer_out_vec,
  output logic          busy,
  output logic [IW-1:0] layer_idx
);

  sched_state_t  state_reg;
  logic [IW-1:0] layer_idx_reg;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_next;
  logic [CW-1:0] cnt_reg;
  logic [VW-1:0] act_reg;
  logic [WW-1:0] w_reg;
  logic [VW-1:0] b_reg;
  logic          last_layer;

  // Zero layers still means one pass; requests beyond the memory depth saturate.
  always_comb begin
    k_next = host.num_layers_cfg;
    if (host.num_layers_cfg == '0)
      k_next = KW'(1);
    else if (host.num_layers_cfg > KW'(NUM_LAYERS))
      k_next = KW'(NUM_LAYERS);
  end

  assign last_layer = (KW'(layer_idx_reg) == k_reg - KW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      layer_idx_reg <= '0;
      k_reg         <= KW'(1);
      cnt_reg       <= '0;
      act_reg       <= '0;
      w_reg         <= '0;
      b_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (host.in_valid) begin
            act_reg       <= host.in_vec;
            layer_idx_reg <= '0;
            k_reg         <= k_next;
            state_reg     <= FETCH;
          end
        end
        FETCH: state_reg <= LOAD;
        LOAD: begin
          // Memory data arrives exactly one cycle after the read strobe.
          w_reg     <= wmem_weights;
          b_reg     <= wmem_biases;
          cnt_reg   <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          if (cnt_reg == CW'(LAYER_LATENCY - 1))
            state_reg <= CAPTURE;
          else
            cnt_reg <= cnt_reg + CW'(1);
        end
        CAPTURE: begin
          act_reg <= layer_out_vec;
          if (last_layer) begin
            state_reg <= DONE;
          end else begin
            layer_idx_reg <= layer_idx_reg + IW'(1);
            state_reg     <= FETCH;
          end
        end
        DONE: begin
          if (host.out_ready)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign host.in_ready  = (state_reg == IDLE);
  assign host.out_valid = (state_reg == DONE);
  assign host.out_vec   = act_reg;
  assign busy           = (state_reg != IDLE);
  assign wmem_rd_en     = (state_reg == FETCH);
  assign wmem_addr      = layer_idx_reg;
  assign layer_idx      = layer_idx_reg;

  // Layer inputs come straight from registers so they only move in LOAD/CAPTURE.
  assign layer_in_vec  = act_reg;
  assign layer_weights = w_reg;
  assign layer_biases  = b_reg;

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench: Layer stub (out=in+bias) and 1-cycle weight memory around the scheduler.
module tb_layer_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NL = 4;
  localparam int LL = 3;
  localparam int IW = 2;
  localparam int KW = 3;
  localparam int VW = N * DW;
  localparam int WW = N * N * DW;

  logic          clk;
  logic          rst;
  logic          wmem_rd_en;
  logic [IW-1:0] wmem_addr;
  logic [WW-1:0] wmem_weights;
  logic [VW-1:0] wmem_biases;
  logic [VW-1:0] layer_in_vec;
  logic [WW-1:0] layer_weights;
  logic [VW-1:0] layer_biases;
  logic [VW-1:0] layer_out_vec;
  logic          busy;
  logic [IW-1:0] layer_idx;

  int checks = 0;
  int errors = 0;

  layer_scheduler_if #(.N(N), .DATA_WIDTH(DW), .NUM_LAYERS(NL)) host_if ();

  layer_scheduler #(.N(N), .DATA_WIDTH(DW), .NUM_LAYERS(NL), .LAYER_LATENCY(LL)) dut (
    .clk(clk), .rst(rst), .host(host_if),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr),
    .wmem_weights(wmem_weights), .wmem_biases(wmem_biases),
    .layer_in_vec(layer_in_vec), .layer_weights(layer_weights),
    .layer_biases(layer_biases), .layer_out_vec(layer_out_vec),
    .busy(busy), .layer_idx(layer_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory model
  logic [WW-1:0] mem_w [NL];
  logic [VW-1:0] mem_b [NL];
  always @(posedge clk) begin
    if (wmem_rd_en) begin
      wmem_weights <= mem_w[wmem_addr];
      wmem_biases  <= mem_b[wmem_addr];
    end
  end

  // Layer stub: LL-deep pipeline, out[i] = in[i] + b[i]
  logic [VW-1:0] stage [LL];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      stage[0][i*DW +: DW] <= layer_in_vec[i*DW +: DW] + layer_biases[i*DW +: DW];
    for (int s = 1; s < LL; s++)
      stage[s] <= stage[s-1];
  end
  assign layer_out_vec = stage[LL-1];

  // Monitors: read-address log, layer-input stability in RUN, weight routing
  int unsigned addr_q[$];
  int stab_err = 0;
  int wsel_err = 0;
  int phase = -1;
  logic [VW-1:0] snap_in, snap_b;
  logic [WW-1:0] snap_w;
  always @(negedge clk) begin
    if (wmem_rd_en) addr_q.push_back(int'(wmem_addr));
    if (rst) phase = -1;
    else if (wmem_rd_en) phase = 0;
    else if (phase >= 0) phase = phase + 1;
    if (phase == 2) begin
      snap_in = layer_in_vec; snap_w = layer_weights; snap_b = layer_biases;
      if (layer_weights !== mem_w[layer_idx] || layer_biases !== mem_b[layer_idx]) wsel_err++;
    end else if (phase == 3 || phase == 4) begin
      if (layer_in_vec !== snap_in || layer_weights !== snap_w || layer_biases !== snap_b) stab_err++;
    end else if (phase > 4) begin
      phase = -1;
    end
  end

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [VW-1:0] v;
    v = {DW'(d), DW'(c), DW'(b), DW'(a)};
    return v;
  endfunction

  function automatic int eff_layers(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > NL) return NL;
    return cfg;
  endfunction

  // Reference: every layer adds its bias vector to the activations, element-wise, mod 2^DW
  function automatic logic [VW-1:0] model(input logic [VW-1:0] v, input int cfg);
    logic [VW-1:0] acc;
    acc = v;
    for (int l = 0; l < eff_layers(cfg); l++)
      for (int i = 0; i < N; i++)
        acc[i*DW +: DW] = acc[i*DW +: DW] + mem_b[l][i*DW +: DW];
    return acc;
  endfunction

  task automatic fill_mem_random();
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < N*N; k++) mem_w[l][k*DW +: DW] = DW'($urandom);
      for (int i = 0; i < N; i++) mem_b[l][i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic run_job(input logic [VW-1:0] v, input int cfg, input bit early_ready,
                         output int lat, output logic [VW-1:0] got);
    int cyc;
    addr_q.delete();
    @(negedge clk);
    host_if.in_vec = v;
    host_if.num_layers_cfg = KW'(cfg);
    host_if.in_valid = 1'b1;
    host_if.out_ready = early_ready;
    @(posedge clk); #1;
    host_if.in_valid = 1'b0;
    cyc = 0;
    lat = -1;
    while (cyc < 200 && !host_if.out_valid) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (host_if.out_valid) lat = cyc;
    got = host_if.out_vec;
    host_if.out_ready = 1'b1;
    @(posedge clk); #1;
    host_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (host_if.in_ready !== 1'b1 || host_if.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               host_if.in_ready, host_if.out_valid, busy);
    end
    checks++;
    if (wmem_rd_en !== 1'b0 || layer_idx !== '0 || wmem_addr !== '0) begin
      errors++;
      $display("FAIL reset_mem: rd_en=%b layer_idx=%0d addr=%0d, required 0 0 0",
               wmem_rd_en, layer_idx, wmem_addr);
    end
    checks++;
    if (host_if.out_vec !== '0 || layer_weights !== '0 || layer_biases !== '0 || layer_in_vec !== '0) begin
      errors++;
      $display("FAIL reset_regs: out_vec=%h w=%h b=%h in=%h, required all zero",
               host_if.out_vec, layer_weights, layer_biases, layer_in_vec);
    end
    $display("reset: in_ready=%b busy=%b", host_if.in_ready, busy);
  endtask

  task automatic test_single_layer();
    int lat;
    logic [VW-1:0] got, exp_v;
    mem_b[0] = pack4(10, 10, 10, 10);
    exp_v = pack4(11, 12, 13, 14);
    run_job(pack4(1, 2, 3, 4), 1, 1'b0, lat, got);
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required 6", lat);
    end
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL single_result: got %h, required %h", got, exp_v);
    end
    checks++;
    if (addr_q.size() != 1 || addr_q[0] != 0) begin
      errors++;
      $display("FAIL single_reads: %0d reads (first %0d), required 1 read at 0",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1);
    end
    $display("single: lat=%0d out=%h", lat, got);
  endtask

  task automatic test_three_layers();
    int lat, s0, w0;
    logic [VW-1:0] got, exp_v;
    bit seq_ok;
    mem_b[0] = pack4(1, 1, 1, 1);
    mem_b[1] = pack4(2, 2, 2, 2);
    mem_b[2] = pack4(3, 3, 3, 3);
    exp_v = pack4(6, 6, 6, 6);
    s0 = stab_err;
    w0 = wsel_err;
    run_job('0, 3, 1'b0, lat, got);
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL three_latency: got %0d cycles, required 18", lat);
    end
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL three_result: got %h, required %h", got, exp_v);
    end
    seq_ok = (addr_q.size() == 3);
    for (int i = 0; i < addr_q.size() && seq_ok; i++) if (addr_q[i] != i) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL three_addr_seq: %0d reads, required addresses 0,1,2", addr_q.size());
    end
    checks++;
    if (stab_err != s0 || wsel_err != w0) begin
      errors++;
      $display("FAIL three_layer_inputs: %0d unstable cycles, %0d wrong weight/bias loads, required 0 0",
               stab_err - s0, wsel_err - w0);
    end
    $display("three: lat=%0d out=%h reads=%0d", lat, got, addr_q.size());
  endtask

  task automatic test_backpressure();
    int cyc, bad;
    logic [VW-1:0] held, exp_v;
    mem_b[0] = pack4(5, 6, 7, 8);
    exp_v = pack4(6, 8, 10, 12);
    addr_q.delete();
    @(negedge clk);
    host_if.in_vec = pack4(1, 2, 3, 4);
    host_if.num_layers_cfg = KW'(1);
    host_if.in_valid = 1'b1;
    host_if.out_ready = 1'b0;
    @(posedge clk); #1;
    host_if.in_vec = pack4(99, 98, 97, 96);
    cyc = 0;
    while (cyc < 50 && !host_if.out_valid) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles, required 6", cyc);
    end
    held = host_if.out_vec;
    checks++;
    if (held !== exp_v) begin
      errors++;
      $display("FAIL bp_result: got %h, required %h", held, exp_v);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (host_if.out_vec !== held || host_if.out_valid !== 1'b1 || host_if.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles lost out_vec/out_valid or raised in_ready, required 0", bad);
    end
    host_if.in_valid = 1'b0;
    host_if.out_ready = 1'b1;
    @(posedge clk); #1;
    host_if.out_ready = 1'b0;
    checks++;
    if (host_if.in_ready !== 1'b1 || host_if.out_valid !== 1'b0 || addr_q.size() != 1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b reads=%0d, required 1 0 1",
               host_if.in_ready, host_if.out_valid, addr_q.size());
    end
    $display("backpressure: held=%h stalled_bad=%0d", held, bad);
  endtask

  task automatic test_mid_run_reset();
    int seen, lat;
    logic [VW-1:0] got, exp_v;
    fill_mem_random();
    addr_q.delete();
    @(negedge clk);
    host_if.in_vec = pack4(3, 1, 4, 1);
    host_if.num_layers_cfg = KW'(3);
    host_if.in_valid = 1'b1;
    @(posedge clk); #1;
    host_if.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (layer_idx !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_prestate: layer_idx=%0d busy=%b, required 1 1", layer_idx, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || host_if.in_ready !== 1'b1 || layer_idx !== '0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b in_ready=%b layer_idx=%0d, required 0 1 0",
               busy, host_if.in_ready, layer_idx);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (host_if.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_output: out_valid seen %0d cycles, required 0", seen);
    end
    exp_v = model(pack4(20, 30, 40, 50), 1);
    run_job(pack4(20, 30, 40, 50), 1, 1'b0, lat, got);
    checks++;
    if (got !== exp_v || lat != 6) begin
      errors++;
      $display("FAIL midrst_next_job: got %h lat %0d, required %h lat 6", got, lat, exp_v);
    end
    $display("midrst: after-reset job out=%h lat=%0d", got, lat);
  endtask

  task automatic test_clamp();
    int lat;
    logic [VW-1:0] got, exp_v;
    bit seq_ok;
    fill_mem_random();
    exp_v = model(pack4(7, 7, 7, 7), 0);
    run_job(pack4(7, 7, 7, 7), 0, 1'b0, lat, got);
    checks++;
    if (lat != 6 || got !== exp_v || addr_q.size() != 1) begin
      errors++;
      $display("FAIL clamp_zero: lat %0d out %h reads %0d, required lat 6 out %h reads 1",
               lat, got, addr_q.size(), exp_v);
    end
    exp_v = model(pack4(9, 8, 7, 6), 7);
    run_job(pack4(9, 8, 7, 6), 7, 1'b0, lat, got);
    seq_ok = (addr_q.size() == NL);
    for (int i = 0; i < addr_q.size() && seq_ok; i++) if (addr_q[i] != i) seq_ok = 0;
    checks++;
    if (lat != 24 || got !== exp_v || !seq_ok) begin
      errors++;
      $display("FAIL clamp_over: lat %0d out %h reads %0d seq_ok %0d, required lat 24 out %h reads 0..3",
               lat, got, addr_q.size(), seq_ok, exp_v);
    end
    $display("clamp: K=7 lat=%0d out=%h", lat, got);
  endtask

  task automatic test_random();
    int lat, cfg, s0, w0;
    bit early, seq_ok;
    logic [VW-1:0] v, got, exp_v;
    for (int it = 0; it < 8; it++) begin
      fill_mem_random();
      v = VW'($urandom);
      cfg = $urandom_range(0, 7);
      early = 1'($urandom_range(0, 1));
      exp_v = model(v, cfg);
      s0 = stab_err;
      w0 = wsel_err;
      run_job(v, cfg, early, lat, got);
      seq_ok = (addr_q.size() == eff_layers(cfg));
      for (int i = 0; i < addr_q.size() && seq_ok; i++) if (addr_q[i] != i) seq_ok = 0;
      checks++;
      if (got !== exp_v || lat != eff_layers(cfg) * (LL + 3) || !seq_ok
          || stab_err != s0 || wsel_err != w0) begin
        errors++;
        $display("FAIL random_%0d: cfg %0d out %h lat %0d seq_ok %0d instab %0d wsel %0d, required out %h lat %0d",
                 it, cfg, got, lat, seq_ok, stab_err - s0, wsel_err - w0,
                 exp_v, eff_layers(cfg) * (LL + 3));
      end
      $display("random %0d: cfg=%0d early_ready=%0d out=%h lat=%0d", it, cfg, early, got, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    host_if.in_valid = 1'b0;
    host_if.in_vec = '0;
    host_if.num_layers_cfg = '0;
    host_if.out_ready = 1'b0;
    fill_mem_random();
    test_reset();
    test_single_layer();
    test_three_layers();
    test_backpressure();
    test_mid_run_reset();
    test_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Sequences a multi-layer fully-connected inference through one shared Layer datapath instance (N inputs, N outputs, fixed pipeline latency).
- Accepts an input activation vector over a valid/ready handshake, then runs layers 0..K-1 in turn. For each layer it fetches that layer's weights and biases from a weight memory, holds them stable at the Layer inputs, and feeds the layer result back as the next layer's input.
- Presents the final activation vector on a valid/ready output. Sits in the NPU core between the host-side stream and the Layer/weight-memory pair.

Parameters:
N, 4, inputs and outputs per layer (square layers, so feedback is legal)
DATA_WIDTH, 8, activation/weight/bias element width, signed
NUM_LAYERS, 4, maximum layers per inference (weight memory depth)
LAYER_LATENCY, 3, Layer pipeline stages (cycles from stable inputs to valid out_vec)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  scheduler can accept a vector
in_vec  in  N*DATA_WIDTH  packed input activations, element i at [i*DATA_WIDTH +: DATA_WIDTH]
num_layers_cfg  in  $clog2(NUM_LAYERS+1)  layer count K, sampled at accept
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_vec  out  N*DATA_WIDTH  packed final activations
wmem_rd_en  out  1  weight memory read strobe
wmem_addr  out  $clog2(NUM_LAYERS)  layer index to read
wmem_weights  in  N*N*DATA_WIDTH  weights, element (out i, in j) at [(i*N+j)*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after rd_en
wmem_biases  in  N*DATA_WIDTH  biases, same timing
layer_in_vec  out  N*DATA_WIDTH  to Layer in_vec
layer_weights  out  N*N*DATA_WIDTH  to Layer weights
layer_biases  out  N*DATA_WIDTH  to Layer biases
layer_out_vec  in  N*DATA_WIDTH  from Layer out_vec
busy  out  1  high in any state other than IDLE
layer_idx  out  $clog2(NUM_LAYERS)  current layer being processed

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, wmem_rd_en=0, wmem_addr=0, layer_idx=0; activation, weight and bias registers plus out_vec cleared to 0.
- Reset during any state aborts the job: next cycle is IDLE, no out_valid is produced, and the partial result is discarded.
- States: IDLE -> FETCH -> LOAD -> RUN -> CAPTURE -> (FETCH | DONE) -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: act_reg<=in_vec, layer_idx<=0, K<=clamp(num_layers_cfg); go to FETCH.
  - Clamp rule: 0 becomes 1; values above NUM_LAYERS become NUM_LAYERS.
- FETCH (1 cycle): wmem_rd_en=1, wmem_addr=layer_idx.
- LOAD (1 cycle): w_reg<=wmem_weights, b_reg<=wmem_biases.
- RUN (LAYER_LATENCY cycles, counted by cnt from 0 to LAYER_LATENCY-1): layer_in_vec/layer_weights/layer_biases are driven from act_reg/w_reg/b_reg and held stable.
- CAPTURE (1 cycle): act_reg<=layer_out_vec.
  - If layer_idx==K-1, go to DONE.
  - Otherwise layer_idx<=layer_idx+1 and go to FETCH.
- The Layer input buses are register outputs at all times and change only in LOAD (weights, biases) and CAPTURE (activations).
- DONE:
  - out_valid=1 and out_vec=act_reg, held stable until out_valid&&out_ready.
  - On that handshake, next state is IDLE.
  - in_ready=0 in DONE; a new accept is possible at the earliest one cycle after the output handshake.
- Per-layer cost is LAYER_LATENCY+3 cycles. out_valid rises exactly K*(LAYER_LATENCY+3) cycles after the accept edge (6 for K=1, L=3).
- Arithmetic is owned by Layer; the scheduler does no arithmetic on data and passes the DATA_WIDTH-wide Layer output unchanged.
- Boundaries:
  - in_valid while busy is ignored and not latched.
  - out_ready high before out_valid has no effect.
  - layer_idx never exceeds K-1, so no wrap-around.
  - Weight-memory read latency is exactly 1 cycle.

Decomposition:
- Shared package npu_pkg holds:
  - sched_state_t enum {IDLE, FETCH, LOAD, RUN, CAPTURE, DONE};
  - localparam function for layer index width ($clog2 of NUM_LAYERS, minimum 1).
- No sub-module inside the scheduler.
- Layer and weight memory are instantiated beside it in the NPU core top.

Test Plan:
- Bench replaces Layer with a stub: LAYER_LATENCY-deep register chain computing out[i]=in[i]+b[i], weights ignored. Weight memory is a 1-cycle-latency array model.
- Reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, wmem_rd_en=0, layer_idx=0.
- Single layer: K=1, in_vec={1,2,3,4}, biases[0]={10,10,10,10} -> out_valid exactly 6 cycles after accept, out_vec={11,12,13,14}; one rd_en pulse with addr=0.
- Three layers: K=3, in_vec={0,0,0,0}, biases[0..2]={1,..},{2,..},{3,..} -> out_vec={6,6,6,6} after 18 cycles; wmem_addr sequence 0,1,2; layer inputs checked constant throughout every RUN.
- Backpressure: out_ready=0 for 5 cycles after out_valid with in_valid held high -> out_vec stable, in_ready=0, nothing accepted; after the handshake, in_ready=1 the next cycle.
- Mid-run reset: rst pulsed during RUN of layer 1 of a K=3 job -> IDLE next cycle, out_valid never asserts; the following K=1 job gives the correct result.
- Config clamp: K=0 -> runs 1 layer (6 cycles); K=7 with NUM_LAYERS=4 -> runs 4 layers (24 cycles), addr sequence 0..3.
